// File: rtl/sram_arbiter_if.sv
// ============================================================================
// Module : sram_arbiter_if
// Brief  : CPU, video and SRAM pin bundle shared by the SRAM arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sram_arbiter_if #(
    parameter int ADDR_W = 18
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [15:0]       cpu_a;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              cpu_wait;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_a;
    logic              vid_ack;
    logic [15:0]       vid_data;
    logic [ADDR_W-1:0] sram_a;
    logic [15:0]       sram_do;
    logic [15:0]       sram_di;
    logic              sram_oe_dq;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic [1:0]        sram_be_n;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_wr, cpu_a, cpu_dout, vid_req, vid_a, sram_di,
        output cpu_din, cpu_wait, vid_ack, vid_data,
        output sram_a, sram_do, sram_oe_dq, sram_we_n, sram_oe_n, sram_be_n
    );

    // Requester / SRAM side
    modport master (
        output cpu_req, cpu_wr, cpu_a, cpu_dout, vid_req, vid_a, sram_di,
        input  cpu_din, cpu_wait, vid_ack, vid_data,
        input  sram_a, sram_do, sram_oe_dq, sram_we_n, sram_oe_n, sram_be_n
    );
endinterface

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module : sram_arbiter
// Brief  : Shares one 16-bit SRAM between the Z80 byte port and video word
//          reads; optional stall counter enabled by ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int ACC_CYC  = 2,
    parameter int VID_HOLD = 4,
    parameter int CPU_PAGE = 0
) (
    input  wire logic        zclk,
    input  wire logic        reset,
`ifdef ARB_STATS_EN
    output logic [15:0]      o_cpu_stall_cnt,
`endif
    sram_arbiter_if.slave    bus
);

    localparam int                    c_cyc_w    = $clog2(ACC_CYC);
    localparam int                    c_hold_w   = $clog2(VID_HOLD + 1);
    localparam logic [c_cyc_w-1:0]    c_last     = c_cyc_w'(ACC_CYC - 1);
    localparam logic [c_hold_w-1:0]   c_hold_max = c_hold_w'(VID_HOLD);
    localparam logic [ADDR_W-16:0]    c_page     = (ADDR_W - 15)'(CPU_PAGE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPU_RD = 3'd1,
        S_CPU_WR = 3'd2,
        S_VID_RD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_cyc_w-1:0]  r_cyc;
    logic [c_hold_w-1:0] r_hold;
    logic                r_cpu_done;
    logic                r_vid_ack;
    logic                r_lane;
    logic [7:0]          r_wdata;
    logic [7:0]          r_cpu_din;
    logic [15:0]         r_vid_data;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_cpu_pend;
    logic                w_grant_vid;
    logic                w_grant_cpu;
    logic                w_access;
    logic                w_last;
    logic                w_we_n;
    logic                w_oe_n;
    logic                w_oe_dq;
    logic [1:0]          w_be_n;

    // The request that just completed is still high in DONE; it must not re-grant.
    assign w_cpu_pend = bus.cpu_req & ~r_cpu_done;
    assign w_access   = (r_state == S_CPU_RD) || (r_state == S_CPU_WR) || (r_state == S_VID_RD);
    assign w_last     = w_access && (r_cyc == c_last);

    always_ff @(posedge zclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_vid = 1'b0;
        w_grant_cpu = 1'b0;
        w_we_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_oe_dq     = 1'b0;
        w_be_n      = 2'b11;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.vid_req && !(w_cpu_pend && (r_hold == c_hold_max))) begin
                    w_grant_vid = 1'b1;
                    w_next      = S_VID_RD;
                end else if (w_cpu_pend) begin
                    w_grant_cpu = 1'b1;
                    w_next      = bus.cpu_wr ? S_CPU_WR : S_CPU_RD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CPU_RD, S_VID_RD: begin
                w_oe_n = 1'b0;
                w_be_n = 2'b00;
                if (w_last) w_next = S_DONE;
            end
            S_CPU_WR: begin
                // Cycle 0 is address/data setup; strobe only afterwards.
                w_oe_dq = 1'b1;
                w_we_n  = (r_cyc == '0);
                w_be_n  = r_lane ? 2'b01 : 2'b10;
                if (w_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge zclk) begin
        if (reset) begin
            r_cyc      <= '0;
            r_hold     <= '0;
            r_cpu_done <= 1'b0;
            r_vid_ack  <= 1'b0;
            r_lane     <= 1'b0;
            r_wdata    <= '0;
            r_cpu_din  <= '0;
            r_vid_data <= '0;
            r_addr     <= '0;
        end else begin
            r_cpu_done <= w_last && (r_state != S_VID_RD);
            r_vid_ack  <= w_last && (r_state == S_VID_RD);
            r_cyc      <= (w_access && !w_last) ? r_cyc + 1'b1 : '0;

            if (w_grant_cpu) begin
                r_addr  <= {c_page, bus.cpu_a[15:1]};
                r_lane  <= bus.cpu_a[0];
                r_wdata <= bus.cpu_dout;
            end else if (w_grant_vid) begin
                r_addr <= bus.vid_a;
            end

            if (w_last && (r_state == S_CPU_RD)) begin
                r_cpu_din <= r_lane ? bus.sram_di[15:8] : bus.sram_di[7:0];
            end
            if (w_last && (r_state == S_VID_RD)) begin
                r_vid_data <= bus.sram_di;
            end

            // Video burst budget counts raw cpu_req so a held CPU request gets every (VID_HOLD+1)th slot.
            if (!bus.cpu_req || w_grant_cpu) begin
                r_hold <= '0;
            end else if (w_grant_vid && (r_hold != c_hold_max)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign bus.cpu_wait   = bus.cpu_req & ~r_cpu_done;
    assign bus.cpu_din    = r_cpu_din;
    assign bus.vid_ack    = r_vid_ack;
    assign bus.vid_data   = r_vid_data;
    assign bus.sram_a     = r_addr;
    assign bus.sram_do    = {r_wdata, r_wdata};
    assign bus.sram_oe_dq = w_oe_dq;
    assign bus.sram_we_n  = w_we_n;
    assign bus.sram_oe_n  = w_oe_n;
    assign bus.sram_be_n  = w_be_n;

`ifdef ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge zclk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.cpu_wait && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_cpu_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module : tb_sram_arbiter
// Brief  : Scoreboard bench for sram_arbiter with a behavioural SRAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;
    localparam int ADDR_W = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W)) bus();
`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    sram_arbiter #(
        .ADDR_W   (ADDR_W),
        .ACC_CYC  (2),
        .VID_HOLD (4),
        .CPU_PAGE (0)
    ) dut (
        .zclk            (clk),
        .reset           (rst),
`ifdef ARB_STATS_EN
        .o_cpu_stall_cnt (stall_cnt),
`endif
        .bus             (bus)
    );

    // SRAM model: async read, write at clock edge while strobe low
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic        load;
    always @(posedge clk) begin
        if (load) begin
            mem[18'h00000] <= 16'h1234;
            mem[18'h00001] <= 16'h5566;
            mem[18'h00002] <= 16'h4400;
            mem[18'h00100] <= 16'hCAFE;
            mem[18'h3FFFF] <= 16'hBEEF;
        end else if (!bus.sram_we_n && bus.sram_oe_dq) begin
            if (!bus.sram_be_n[0]) mem[bus.sram_a][7:0]  <= bus.sram_do[7:0];
            if (!bus.sram_be_n[1]) mem[bus.sram_a][15:8] <= bus.sram_do[15:8];
        end
    end
    assign bus.sram_di = mem[bus.sram_a];

    // kind: 0 = CPU read, 1 = CPU write, 2 = video read
    typedef struct {
        int          kind;
        logic [15:0] data;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && mon_en) begin
            if (bus.vid_ack) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_vid", 32'd2, 32'd255);
                end else begin
                    e = q.pop_front();
                    chk("sb_kind_vid", 32'd2, e.kind);
                    if (e.kind == 2) chk("vid_data", {16'h0, bus.vid_data}, {16'h0, e.data});
                end
            end
            if (bus.cpu_req && !bus.cpu_wait) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_cpu", {31'h0, bus.cpu_wr}, 32'd255);
                end else begin
                    e = q.pop_front();
                    chk("sb_kind_cpu", {31'h0, bus.cpu_wr}, e.kind);
                    if (e.kind == 0) chk("cpu_din", {24'h0, bus.cpu_din}, {24'h0, e.data[7:0]});
                end
            end
        end
    end

    task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                              output int waitc, output int welow, output logic [1:0] be);
        waitc = 0;
        welow = 0;
        be    = 2'b11;
        @(posedge clk);
        #1;
        bus.cpu_wr   = wr;
        bus.cpu_a    = a;
        bus.cpu_dout = d;
        bus.cpu_req  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.sram_we_n) begin
                welow++;
                be = bus.sram_be_n;
            end
            if (bus.cpu_wait) waitc++;
            else break;
        end
        #1 bus.cpu_req = 1'b0;
    endtask

    task automatic vid_burst(input logic [ADDR_W-1:0] a, input int n,
                             output int first, output int min_i, output int max_i);
        int cnt  = 0;
        int last = 0;
        first = -1;
        min_i = 999;
        max_i = 0;
        @(posedge clk);
        #1;
        bus.vid_a   = a;
        bus.vid_req = 1'b1;
        for (int i = 0; i < 200 && cnt < n; i++) begin
            @(negedge clk);
            if (bus.vid_ack) begin
                if (cnt == 0) first = i;
                else begin
                    if (i - last < min_i) min_i = i - last;
                    if (i - last > max_i) max_i = i - last;
                end
                last = i;
                cnt++;
            end
        end
        #1 bus.vid_req = 1'b0;
    endtask

    int          wc, wl, first, mn, mx, run, maxrun, ncpu;
    logic [1:0]  be;
    bit          done_ok;

    initial begin
        bus.cpu_req  = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_a    = '0;
        bus.cpu_dout = '0;
        bus.vid_req  = 1'b0;
        bus.vid_a    = '0;
        load         = 1'b1;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1 load = 1'b0;

        @(negedge clk);
        chk("rst_we_n",  {31'h0, bus.sram_we_n},  32'd1);
        chk("rst_oe_n",  {31'h0, bus.sram_oe_n},  32'd1);
        chk("rst_be_n",  {30'h0, bus.sram_be_n},  32'd3);
        chk("rst_oe_dq", {31'h0, bus.sram_oe_dq}, 32'd0);
        chk("rst_addr",  {14'h0, bus.sram_a},     32'd0);
        chk("rst_ack",   {31'h0, bus.vid_ack},    32'd0);
        chk("rst_din",   {24'h0, bus.cpu_din},    32'd0);
        chk("rst_vdata", {16'h0, bus.vid_data},   32'd0);
        chk("rst_wait",  {31'h0, bus.cpu_wait},   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle-bus CPU read of the high lane of word 0
        push(0, 16'h0012);
        cpu_access(1'b0, 16'h0001, 8'h00, wc, wl, be);
        chk("rd_wait_cycles", wc, 32'd3);
        chk("rd_no_strobe", wl, 32'd0);

        // Low-lane write then read back both lanes of word 1
        push(1, 16'h0000);
        cpu_access(1'b1, 16'h0002, 8'hAB, wc, wl, be);
        chk("wr_wait_cycles", wc, 32'd3);
        chk("wr_we_low_cycles", wl, 32'd1);
        chk("wr_be_lo", {30'h0, be}, 32'd2);
        push(0, 16'h00AB);
        cpu_access(1'b0, 16'h0002, 8'h00, wc, wl, be);
        push(0, 16'h0055);
        cpu_access(1'b0, 16'h0003, 8'h00, wc, wl, be);

        // High-lane write to word 0x100 (0xCAFE -> 0x77FE)
        push(1, 16'h0000);
        cpu_access(1'b1, 16'h0201, 8'h77, wc, wl, be);
        chk("wr_be_hi", {30'h0, be}, 32'd1);
        chk("wr_hi_we_low_cycles", wl, 32'd1);
        push(0, 16'h00FE);
        cpu_access(1'b0, 16'h0200, 8'h00, wc, wl, be);
        push(0, 16'h0077);
        cpu_access(1'b0, 16'h0201, 8'h00, wc, wl, be);

        // Video-only burst at the top word
        repeat (4) push(2, 16'hBEEF);
        vid_burst(18'h3FFFF, 4, first, mn, mx);
        chk("vid_first_ack", first, 32'd3);
        chk("vid_min_interval", mn, 32'd3);
        chk("vid_max_interval", mx, 32'd3);

        // Contention: both requests held -> V,V,V,V,C,V,V,V,V,C
        repeat (4) push(2, 16'h1234);
        push(0, 16'h0055);
        repeat (4) push(2, 16'h1234);
        push(0, 16'h0055);
        run = 0; maxrun = 0; ncpu = 0;
        @(posedge clk);
        #1;
        bus.vid_a   = '0;
        bus.vid_req = 1'b1;
        bus.cpu_wr  = 1'b0;
        bus.cpu_a   = 16'h0003;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 200 && ncpu < 2; i++) begin
            @(negedge clk);
            if (bus.cpu_wait) run++;
            else begin
                if (run > maxrun) maxrun = run;
                run = 0;
                ncpu++;
            end
        end
        #1;
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        chk("cont_cpu_grants", ncpu, 32'd2);
        chk("cont_max_wait", maxrun, 32'd15);

        // Reset while the write strobe is active
        push(1, 16'h0000);
        @(posedge clk);
        #1;
        bus.cpu_wr   = 1'b1;
        bus.cpu_a    = 16'h0004;
        bus.cpu_dout = 8'h99;
        bus.cpu_req  = 1'b1;
        repeat (3) @(negedge clk);
        chk("wr_strobe_before_rst", {31'h0, bus.sram_we_n}, 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_we_n",  {31'h0, bus.sram_we_n},  32'd1);
        chk("midrst_oe_dq", {31'h0, bus.sram_oe_dq}, 32'd0);
        chk("midrst_be_n",  {30'h0, bus.sram_be_n},  32'd3);
        chk("midrst_wait",  {31'h0, bus.cpu_wait},   32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        done_ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.cpu_wait) begin
                done_ok = 1'b1;
                break;
            end
        end
        #1 bus.cpu_req = 1'b0;
        chk("postrst_write_done", {31'h0, done_ok}, 32'd1);
        push(0, 16'h0099);
        cpu_access(1'b0, 16'h0004, 8'h00, wc, wl, be);
        push(0, 16'h0044);
        cpu_access(1'b0, 16'h0005, 8'h00, wc, wl, be);

        repeat (5) @(negedge clk);
        chk("sb_drain", q.size(), 32'd0);

`ifdef ARB_STATS_EN
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("stall_after_rst", {16'h0, stall_cnt}, 32'd0);
        // 3 idle read + 4 (request raised during video cycle 1) + 3 idle read
        push(0, 16'h0034);
        cpu_access(1'b0, 16'h0000, 8'h00, wc, wl, be);
        push(2, 16'h1234);
        push(0, 16'h0012);
        @(posedge clk);
        #1;
        bus.vid_a   = '0;
        bus.vid_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.cpu_wr  = 1'b0;
        bus.cpu_a   = 16'h0001;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.vid_ack) #1 bus.vid_req = 1'b0;
            else if (bus.cpu_req && !bus.cpu_wait) break;
        end
        #1 bus.cpu_req = 1'b0;
        push(0, 16'h0012);
        cpu_access(1'b0, 16'h0001, 8'h00, wc, wl, be);
        @(negedge clk);
        chk("stall_count_10", {16'h0, stall_cnt}, 32'd10);

        mon_en = 1'b0;
        @(posedge clk);
        #1;
        bus.vid_req = 1'b1;
        bus.cpu_req = 1'b1;
        repeat (75000) @(posedge clk);
        #1;
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_saturate", {16'h0, stall_cnt}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

`default_nettype wire
